// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-organised SRAM.
// Single transfers with configurable wait states, byte-lane writes and a two-cycle ERROR response.
module ahb_sram_subordinate #(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int MemDepthWords = 1024,
  parameter int WaitStates    = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     hsel,
  input  logic [AddressWidth-1:0]  haddr,
  input  logic [1:0]               htrans,
  input  logic                     hwrite,
  input  logic [2:0]               hsize,
  input  logic [2:0]               hburst,
  input  logic [DataWidth/8-1:0]   hwstrb,
  input  logic [DataWidth-1:0]     hwdata,
  input  logic                     hready,
  output logic                     hreadyout,
  output logic                     hresp,
  output logic [DataWidth-1:0]     hrdata
);

  localparam int NumBytes = DataWidth / 8;
  localparam int LaneBits = $clog2(NumBytes);
  localparam int MemBytes = MemDepthWords * NumBytes;
  localparam int IdxWidth = $clog2(MemDepthWords);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } stateT;

  stateT                   state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;

  logic                    canAccept;
  logic                    accept;
  logic                    sizeBad;
  logic                    misaligned;
  logic                    outOfRange;
  logic                    illegal;
  logic [IdxWidth-1:0]     wordIdx;
  logic [NumBytes-1:0]     laneSel;
  int                      byteOff;
  logic                    unusedInputs;

  logic [DataWidth-1:0]    mem [MemDepthWords];

  // Burst type and the Busy/Sequential distinction do not affect decode.
  assign unusedInputs = ^{hburst, htrans[0]};

  assign canAccept  = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = canAccept && hsel && hready && htrans[1];
  assign sizeBad    = {29'd0, hsize} > 32'(LaneBits);
  assign misaligned = (32'(haddr) & ((32'd1 << hsize) - 32'd1)) != 32'd0;
  assign outOfRange = 64'(haddr) >= 64'(MemBytes);
  assign illegal    = sizeBad || misaligned || outOfRange;

  assign wordIdx = IdxWidth'(32'(addr_q) / NumBytes);

  // A lane belongs to the transfer when it shares the size-aligned chunk of the captured address.
  always_comb begin
    byteOff = int'(32'(addr_q) % NumBytes);
    laneSel = '0;
    for (int i = 0; i < NumBytes; i++) begin
      laneSel[i] = ((i ^ byteOff) >> size_q) == 0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StData;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d = StIdle;
        if (accept) begin
          addr_d  = haddr;
          write_d = hwrite;
          size_d  = hsize;
          if (illegal) begin
            state_d = StErr1;
          end else if (WaitStates > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WaitStates);
          end else begin
            state_d = StData;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // SRAM has no reset; a write lands only on the edge that closes its DATA cycle.
  always_ff @(posedge hclk) begin
    if (state_q == StData && write_q) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (hwstrb[i] && laneSel[i]) begin
          mem[wordIdx][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    hreadyout = !((state_q == StWait) || (state_q == StErr1));
    hresp     = (state_q == StErr1) || (state_q == StErr2);
    hrdata    = '0;
    if (state_q == StData) begin
      hrdata = mem[wordIdx];
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Scoreboard bench: one subordinate with two wait states and one with none, sharing the bus inputs.
module tb_ahb_sram_subordinate;

  typedef struct {
    bit          err;
    bit          isRead;
    int          waits;
    logic [31:0] data;
  } expT;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hselBus = 1'b0;
  logic        selWs0 = 1'b0;
  logic [19:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hwstrb = 4'h0;
  logic [31:0] hwdata = '0;

  logic        hsel2, hsel0;
  logic        hreadyout2, hreadyout0;
  logic        hresp2, hresp0;
  logic [31:0] hrdata2, hrdata0;
  logic        rdySel, respSel;
  logic [31:0] rdataSel;

  int checks = 0;
  int errors = 0;
  expT sbQ[$];

  assign hsel2    = hselBus && !selWs0;
  assign hsel0    = hselBus && selWs0;
  assign rdySel   = selWs0 ? hreadyout0 : hreadyout2;
  assign respSel  = selWs0 ? hresp0 : hresp2;
  assign rdataSel = selWs0 ? hrdata0 : hrdata2;

  always #5 hclk = ~hclk;

  ahb_sram_subordinate #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(1024), .WaitStates(2)) dutWs2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata), .hready(hreadyout2),
    .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
  );

  ahb_sram_subordinate #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(1024), .WaitStates(0)) dutWs0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata), .hready(hreadyout0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic driveIdle();
    hselBus = 1'b0;
    htrans  = 2'd0;
    hwrite  = 1'b0;
  endtask

  // Pops the oldest expectation and compares it with what the data phase showed.
  task automatic scoreTransfer(input string tag, input int lowCnt, input logic firstResp,
                               input logic [31:0] firstRdata, input logic finalResp,
                               input logic [31:0] finalRdata);
    expT e;
    e = sbQ.pop_front();
    checkOutput({tag, ".waits"}, 32'(lowCnt), 32'(e.waits));
    checkOutput({tag, ".firstResp"}, {31'd0, firstResp}, {31'd0, e.err});
    checkOutput({tag, ".finalResp"}, {31'd0, finalResp}, {31'd0, e.err});
    if (e.isRead || e.err) checkOutput({tag, ".rdata"}, finalRdata, e.data);
    if (e.waits > 0 && !e.err) checkOutput({tag, ".waitRdata"}, firstRdata, 32'd0);
  endtask

  // One non-pipelined transfer; hwdata is garbage while the subordinate stalls.
  task automatic applyStimulus(input string tag, input bit useWs0, input bit wr, input logic [19:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                               input bit expErr, input logic [31:0] expData);
    expT e;
    int lowCnt;
    logic firstResp, finalResp;
    logic [31:0] firstRdata, finalRdata;
    e.err    = expErr;
    e.isRead = !wr;
    e.waits  = expErr ? 1 : (useWs0 ? 0 : 2);
    e.data   = expErr ? 32'd0 : expData;
    sbQ.push_back(e);
    @(negedge hclk);
    selWs0  = useWs0;
    hselBus = 1'b1;
    htrans  = 2'd2;
    haddr   = addr;
    hwrite  = wr;
    hsize   = size;
    hburst  = 3'd0;
    @(posedge hclk);
    @(negedge hclk);
    driveIdle();
    hwdata     = ~wdata;
    hwstrb     = strb;
    lowCnt     = 0;
    firstResp  = respSel;
    firstRdata = rdataSel;
    while (!rdySel && lowCnt < 16) begin
      lowCnt++;
      @(negedge hclk);
    end
    hwdata     = wdata;
    finalResp  = respSel;
    finalRdata = rdataSel;
    scoreTransfer(tag, lowCnt, firstResp, firstRdata, finalResp, finalRdata);
    @(posedge hclk);
  endtask

  // Zero-wait write whose data phase overlaps the address phase of a read to the same word.
  task automatic backToBack(input logic [19:0] addr, input logic [31:0] wdata);
    expT e;
    e.err = 1'b0; e.isRead = 1'b0; e.waits = 0; e.data = 32'd0;
    sbQ.push_back(e);
    e.isRead = 1'b1; e.data = wdata;
    sbQ.push_back(e);
    @(negedge hclk);
    selWs0 = 1'b1; hselBus = 1'b1; htrans = 2'd2; haddr = addr; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    scoreTransfer("b2bWrite", rdySel ? 0 : 1, respSel, rdataSel, respSel, rdataSel);
    hwdata = wdata; hwstrb = 4'hF;
    htrans = 2'd3; hwrite = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    scoreTransfer("b2bRead", rdySel ? 0 : 1, respSel, rdataSel, respSel, rdataSel);
    driveIdle();
    @(posedge hclk);
  endtask

  // Reset lands while a write sits in its wait states; the write must be dropped.
  task automatic resetMidWait(input logic [19:0] addr);
    @(negedge hclk);
    selWs0 = 1'b0; hselBus = 1'b1; htrans = 2'd2; haddr = addr; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    checkOutput("rstWaitReady", {31'd0, hreadyout2}, 32'd0);
    driveIdle();
    hwdata = 32'hFFFF_FFFF; hwstrb = 4'hF;
    #2 hresetn = 1'b0;
    #1;
    checkOutput("rstReady", {31'd0, hreadyout2}, 32'd1);
    checkOutput("rstResp", {31'd0, hresp2}, 32'd0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    @(negedge hclk);
    @(negedge hclk);
    checkOutput("resetReady2", {31'd0, hreadyout2}, 32'd1);
    checkOutput("resetResp2", {31'd0, hresp2}, 32'd0);
    checkOutput("resetRdata2", hrdata2, 32'd0);
    checkOutput("resetReady0", {31'd0, hreadyout0}, 32'd1);
    checkOutput("resetResp0", {31'd0, hresp0}, 32'd0);
    checkOutput("resetRdata0", hrdata0, 32'd0);
    hresetn = 1'b1;

    applyStimulus("wrWord", 0, 1, 20'h10, 3'd2, 32'hDEAD_BEEF, 4'hF, 0, 32'd0);
    applyStimulus("rdWord", 0, 0, 20'h10, 3'd2, 32'd0, 4'h0, 0, 32'hDEAD_BEEF);
    applyStimulus("wrByte", 0, 1, 20'h13, 3'd0, 32'hABFF_FFFF, 4'hF, 0, 32'd0);
    applyStimulus("rdByte", 0, 0, 20'h10, 3'd2, 32'd0, 4'h0, 0, 32'hABAD_BEEF);
    applyStimulus("wrHalfStrb", 0, 1, 20'h12, 3'd1, 32'h1234_FFFF, 4'h4, 0, 32'd0);
    applyStimulus("rdHalfStrb", 0, 0, 20'h10, 3'd2, 32'd0, 4'h0, 0, 32'hAB34_BEEF);

    applyStimulus("wrTop", 0, 1, 20'hFFC, 3'd2, 32'hCAFE_F00D, 4'hF, 0, 32'd0);
    applyStimulus("wrOutOfRange", 0, 1, 20'h1000, 3'd2, 32'h1111_1111, 4'hF, 1, 32'd0);
    applyStimulus("rdTop", 0, 0, 20'hFFC, 3'd2, 32'd0, 4'h0, 0, 32'hCAFE_F00D);
    applyStimulus("rdMisaligned", 0, 0, 20'h11, 3'd1, 32'd0, 4'h0, 1, 32'd0);
    applyStimulus("rdOversize", 0, 0, 20'h10, 3'd3, 32'd0, 4'h0, 1, 32'd0);
    applyStimulus("rdAfterErr", 0, 0, 20'h10, 3'd2, 32'd0, 4'h0, 0, 32'hAB34_BEEF);

    backToBack(20'h20, 32'h1234_5678);
    applyStimulus("rdWs0", 1, 0, 20'h20, 3'd2, 32'd0, 4'h0, 0, 32'h1234_5678);
    applyStimulus("rdWs0Misaligned", 1, 0, 20'h22, 3'd2, 32'd0, 4'h0, 1, 32'd0);

    applyStimulus("wrPrior", 0, 1, 20'h30, 3'd2, 32'h55AA_55AA, 4'hF, 0, 32'd0);
    resetMidWait(20'h30);
    applyStimulus("rdAfterReset", 0, 0, 20'h30, 3'd2, 32'd0, 4'h0, 0, 32'h55AA_55AA);

    repeat (2) @(negedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
